serial_add_sub: RTL and testbench

- Multi-cycle, parametrised N-bit adder/subtractor built on the 1-bit full add/sub cell.
- Captures operands on `start`, then processes BITS_PER_CYCLE bits per clock through a carry flip-flop (LSB first).
- Presents result, carry/borrow, overflow and zero flags with a one-cycle `done` pulse.
- Sits in the datapath library as the area-cheap alternative to a wide ripple add/sub.

---
 rtl/serial_add_sub_pkg.sv | 21 ++
 rtl/add_sub_slice.sv | 31 +++
 rtl/serial_add_sub.sv | 117 +++++++++++
 tb/tb_serial_add_sub.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM state encoding, the operation codes and the beat-counter sizing.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Beat counter width: clog2 of the number of beats, never narrower than one bit.
    function automatic int cnt_width(input int width, input int bits_per_cycle);
        int beats;
        beats = width / bits_per_cycle;
        return ($clog2(beats) < 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational BITS-wide ripple of full-adder cells used once per beat.
// Also exposes the carry into its top bit so the caller can derive signed overflow.
module add_sub_slice #(
    parameter int BITS = 1
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout,
    output logic            c_top
);

    logic c;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        sum   = '0;
        c     = cin;
        c_top = cin;
        for (int i = 0; i < BITS; i++) begin
            if (i == BITS - 1) begin
                c_top = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes BITS_PER_CYCLE bits per clock, LSB first.
// Subtraction is a + ~b + ~cin, so the carry flip-flop holds an inverted borrow while running.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int BEATS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    state_t                    state;
    logic [CNT_W-1:0]          beat;
    logic [WIDTH-1:0]          a_sr;
    logic [WIDTH-1:0]          b_sr;
    logic                      carry;
    logic                      op_sel;

    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic                      slice_cout;
    logic                      slice_c_top;
    logic [WIDTH+BITS_PER_CYCLE-1:0] shifted;
    logic [WIDTH-1:0]          next_result;

    add_sub_slice #(
        .BITS (BITS_PER_CYCLE)
    ) u_slice (
        .a     (a_sr[BITS_PER_CYCLE-1:0]),
        .b     (b_sr[BITS_PER_CYCLE-1:0]),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_top (slice_c_top)
    );

    // Sum bits enter at the MSB end; after BEATS shifts the word is aligned.
    assign shifted     = {slice_sum, result};
    assign next_result = shifted[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            op_sel   <= OP_ADD;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= (select == OP_SUB) ? ~b : b;
                        carry  <= (select == OP_SUB) ? ~cin : cin;
                        op_sel <= select;
                        beat   <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result <= next_result;
                    a_sr   <= a_sr >> BITS_PER_CYCLE;
                    b_sr   <= b_sr >> BITS_PER_CYCLE;
                    carry  <= slice_cout;
                    beat   <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        cout     <= slice_cout ^ op_sel;
                        overflow <= slice_c_top ^ slice_cout;
                        zero     <= (next_result == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector bench for serial_add_sub: an 8-bit/1-bit-per-cycle instance and
// an 8-bit/4-bits-per-cycle instance sharing operands, reset and clock.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       select;

    logic       start1, busy1, done1, cout1, ovf1, zero1;
    logic [7:0] result1;
    logic       start4, busy4, done4, cout4, ovf4, zero4;
    logic [7:0] result4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .select(select),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(ovf1), .zero(zero1)
    );

    serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .select(select),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(ovf4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; holds start across one rising edge and returns at the next negedge.
    task automatic launch(input bit wide, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sel);
        a = av; b = bv; cin = ci; select = sel;
        if (wide) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Counts the current negedge as cycle 1 and stops at the first negedge with done high.
    task automatic wait_done(input bit wide, output int busy_cycles, output int lat, output bit got);
        busy_cycles = 0; lat = 0; got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (wide ? busy4 : busy1) busy_cycles++;
            if (wide ? done4 : done1) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_flags(input string tag, input bit wide, input logic [7:0] res,
                               input logic co, input logic ov, input logic z);
        check({tag, "_result"},   wide ? result4 : result1, res);
        check({tag, "_cout"},     wide ? cout4 : cout1, co);
        check({tag, "_overflow"}, wide ? ovf4 : ovf1, ov);
        check({tag, "_zero"},     wide ? zero4 : zero1, z);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sel,
                          input logic [7:0] res, input logic co, input logic ov, input logic z);
        int  bc, lat;
        bit  got;
        launch(1'b0, av, bv, ci, sel);
        wait_done(1'b0, bc, lat, got);
        check({tag, "_done_seen"}, got, 1);
        check_flags(tag, 1'b0, res, co, ov, z);
        @(negedge clk);
        check({tag, "_done_pulse"}, done1, 0);
    endtask

    initial begin
        int  bc, lat, n_done;
        bit  got;

        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = '0; b = '0; cin = 1'b0; select = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",   busy1, 0);
        check("reset_done",   done1, 0);
        check("reset_result", result1, 0);
        check("reset_flags",  {cout1, ovf1, zero1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: plain add with latency and busy-width checks
        launch(1'b0, 8'd100, 8'd27, 1'b0, 1'b0);
        wait_done(1'b0, bc, lat, got);
        check("add_latency", lat, 9);
        check("add_busy_cycles", bc, 8);
        check_flags("add", 1'b0, 8'd127, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("add_done_pulse", done1, 0);

        // 2-4: wrap, borrow, signed overflow
        run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_borrow",8'h50, 8'h70, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
        run_op("sub_bin",   8'h50, 8'h70, 1'b1, 1'b1, 8'hDF, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

        // 5: start during RUN ignored; start in DONE accepted immediately
        launch(1'b0, 8'h33, 8'h44, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h11; b = 8'h22; select = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b0, bc, lat, got);
        check("busy_start_done", got, 1);
        check("busy_start_lat", lat, 7);
        check_flags("busy_start", 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
        launch(1'b0, 8'h0F, 8'h01, 1'b0, 1'b1);
        check("done_start_busy", busy1, 1);
        check("done_start_done", done1, 0);
        wait_done(1'b0, bc, lat, got);
        check("done_start_lat", lat, 9);
        check_flags("done_start", 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // 6: reset mid-run abandons the operation
        launch(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_result", result1, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done1) n_done++;
        end
        check("rst_no_done", n_done, 0);
        run_op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

        // 4-bits-per-cycle instance
        launch(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(1'b1, bc, lat, got);
        check("w4_latency", lat, 3);
        check("w4_busy_cycles", bc, 2);
        check_flags("w4", 1'b1, 8'h46, 1'b0, 1'b0, 1'b0);
        launch(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(1'b1, bc, lat, got);
        check("w4_sub_done", got, 1);
        check_flags("w4_sub", 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
